// File: rtl/computer_pkg.sv
// Shared definitions for the arithmetic datapath blocks: default operand width,
// FSM state encoding and a counter-width helper.
package computer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width: ceil(log2(w)), kept at least one bit wide.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder, the bit-slice of the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A + B (B arrives already negated), one bit per clock, LSB first.
// Result and flags are registered on completion and held until the next one.
module serial_subtractor
  import computer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_ready,
  output logic [WIDTH-1:0] Output,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             ready
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic             c_int;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_next;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (c_int),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB; on the last step this is the full result.
  assign sum_next = {fa_s, res_sh};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      c_int    <= 1'b0;
      cnt      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      Output   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      ready    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (en && B_ready) begin
            a_sh   <= A;
            b_sh   <= B;
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
            res_sh <= '0;
            c_int  <= 1'b0;
            cnt    <= '0;
            state  <= ADD;
          end
        end

        ADD: begin
          if (!en) begin
            // Abort: previous result and flags stay visible.
            state <= IDLE;
          end else begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= sum_next[WIDTH-1:1];
            c_int  <= fa_cout;
            cnt    <= cnt + CW'(1);
            if (cnt == LAST) begin
              Output   <= sum_next;
              carry    <= fa_cout;
              overflow <= (a_msb == b_msb) && (sum_next[WIDTH-1] != a_msb);
              zero     <= (sum_next == '0);
              ready    <= 1'b1;
              state    <= DONE;
            end
          end
        end

        DONE: begin
          if (!en) begin
            ready <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios plus random
// operands against a plain-arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         b_rdy;
  logic [W-1:0] res;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         ready;

  int total;
  int bad;

  serial_subtractor dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .A        (a_in),
    .B        (b_in),
    .B_ready  (b_rdy),
    .Output   (res),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: sum mod 2^W, unsigned carry, signed overflow, zero.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] s, output logic c,
                       output logic v, output logic z);
    int ua, ub, sa, sb, us, ss;
    ua = int'(a);
    ub = int'(b);
    us = ua + ub;
    s  = W'(us % 256);
    c  = (us >= 256);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    ss = sa + sb;
    v  = (ss > 127) || (ss < -128);
    z  = (us % 256) == 0;
  endtask

  // Start an operation (capture on the first edge), scramble inputs during
  // the add, and return edges from capture until ready (-1 if it never rose).
  task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                output int lat);
    a_in  = a;
    b_in  = b;
    en    = 1'b1;
    b_rdy = 1'b1;
    tick();
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      b_rdy = 1'($urandom);
      tick();
      if (ready === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; b_rdy = 1'b0; a_in = '0; b_in = '0;
    tick();
    tick();
    total++;
    if ({res, carry, overflow, zero, ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {res, carry, overflow, zero, ready});
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic [W-1:0] vs [3];
    logic [2:0]   vf [3];
    int lat;
    va = '{8'h0C, 8'h7F, 8'h05};
    vb = '{8'hF4, 8'h01, 8'hF4};
    vs = '{8'h00, 8'h80, 8'hF9};
    vf = '{3'b101, 3'b010, 3'b000};
    for (int k = 0; k < 3; k++) begin
      en = 1'b0;
      tick();
      start_and_wait(va[k], vb[k], lat);
      total++;
      if (lat !== W) begin
        bad++;
        $display("FAIL directed_latency[%0d] got=%0d want=%0d", k, lat, W);
      end
      total++;
      if (res !== vs[k]) begin
        bad++;
        $display("FAIL directed_result[%0d] got=%h want=%h", k, res, vs[k]);
      end
      total++;
      if ({carry, overflow, zero} !== vf[k]) begin
        bad++;
        $display("FAIL directed_flags[%0d] got=%b want=%b", k, {carry, overflow, zero}, vf[k]);
      end
    end
  endtask

  // In DONE with en high: no restart, outputs hold while inputs move.
  task automatic test_done_hold();
    for (int i = 0; i < 6; i++) begin
      a_in = W'($urandom); b_in = W'($urandom); b_rdy = 1'b1;
      tick();
      total++;
      if ({ready, res, carry, overflow, zero} !== {1'b1, 8'hF9, 3'b000}) begin
        bad++;
        $display("FAIL done_hold got=%h want=%h", {ready, res, carry, overflow, zero},
                 {1'b1, 8'hF9, 3'b000});
      end
    end
  endtask

  // Abort mid-add: result from the previous operation must survive.
  task automatic test_abort();
    en = 1'b0;
    tick();
    total++;
    if ({ready, res} !== {1'b0, 8'hF9}) begin
      bad++;
      $display("FAIL done_to_idle got=%h want=%h", {ready, res}, {1'b0, 8'hF9});
    end
    a_in = 8'h10; b_in = 8'h10; en = 1'b1; b_rdy = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({ready, res, carry, overflow, zero} !== {1'b0, 8'hF9, 3'b000}) begin
        bad++;
        $display("FAIL abort_hold got=%h want=%h", {ready, res, carry, overflow, zero},
                 {1'b0, 8'hF9, 3'b000});
      end
    end
  endtask

  // en high without B_ready: no capture; capture on the edge B_ready rises.
  task automatic test_bready_gate();
    int lat;
    logic [W-1:0] s;
    logic c, v, z;
    en = 1'b1; b_rdy = 1'b0; a_in = 8'h33; b_in = 8'h44;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({ready, res} !== {1'b0, 8'hF9}) begin
        bad++;
        $display("FAIL bready_idle got=%h want=%h", {ready, res}, {1'b0, 8'hF9});
      end
    end
    start_and_wait(8'h33, 8'h44, lat);
    model(8'h33, 8'h44, s, c, v, z);
    total++;
    if (lat !== W) begin
      bad++;
      $display("FAIL bready_latency got=%0d want=%0d", lat, W);
    end
    total++;
    if ({res, carry, overflow, zero} !== {s, c, v, z}) begin
      bad++;
      $display("FAIL bready_result got=%h want=%h", {res, carry, overflow, zero}, {s, c, v, z});
    end
  endtask

  // Reset in DONE with en held high, then an immediate new start.
  task automatic test_reset_in_done();
    int lat;
    logic [W-1:0] s;
    logic c, v, z;
    rst = 1'b1;
    tick();
    total++;
    if ({res, carry, overflow, zero, ready} !== '0) begin
      bad++;
      $display("FAIL reset_in_done got=%h want=0", {res, carry, overflow, zero, ready});
    end
    rst = 1'b0;
    start_and_wait(8'hA5, 8'h9C, lat);
    model(8'hA5, 8'h9C, s, c, v, z);
    total++;
    if (lat !== W) begin
      bad++;
      $display("FAIL restart_latency got=%0d want=%0d", lat, W);
    end
    total++;
    if ({res, carry, overflow, zero} !== {s, c, v, z}) begin
      bad++;
      $display("FAIL restart_result got=%h want=%h", {res, carry, overflow, zero}, {s, c, v, z});
    end
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] a, b, s;
    logic c, v, z;
    for (int k = 0; k < 40; k++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (k == 0) begin a = 8'h80; b = 8'h80; end
      if (k == 1) begin a = 8'hFF; b = 8'h01; end
      en = 1'b0;
      tick();
      start_and_wait(a, b, lat);
      model(a, b, s, c, v, z);
      total++;
      if (lat !== W) begin
        bad++;
        $display("FAIL rand_latency a=%h b=%h got=%0d want=%0d", a, b, lat, W);
      end
      total++;
      if ({res, carry, overflow, zero} !== {s, c, v, z}) begin
        bad++;
        $display("FAIL rand_result a=%h b=%h got=%h want=%h", a, b,
                 {res, carry, overflow, zero}, {s, c, v, z});
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; en = 1'b0; b_rdy = 1'b0; a_in = '0; b_in = '0;
    test_reset();
    test_directed();
    test_done_hold();
    test_abort();
    test_bready_gate();
    test_reset_in_done();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
